dat_mem_stk: RTL and testbench

//  Parametrised DW x 2**AW data memory with a random-access load/store port and a

---
 rtl/dat_mem_stk.sv | 89 ++++++++
 tb/tb_dat_mem_stk.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_stk.sv
// dat_mem_stk: data memory with a random-access load/store port and a downward-growing hardware stack sharing one write port. Optional macro DAT_MEM_RD_REG_EN registers dat_out and stk_top (1-cycle, read-first).
module dat_mem_stk #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int STACK_BASE  = 255,
    parameter int STACK_LIMIT = 192
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    input  logic          wr_en,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    output logic [DW-1:0] dat_out,
    output logic [DW-1:0] stk_top,
    output logic [AW-1:0] sp,
    output logic          full,
    output logic          empty,
    output logic [2:0]    err
);
    localparam int DEPTH = STACK_BASE - STACK_LIMIT + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] depth_c = CW'(DEPTH);
    localparam logic [CW-1:0] one_c = CW'(1);
    localparam logic [AW-1:0] one_a = AW'(1);
    localparam logic [AW-1:0] base_a = AW'(STACK_BASE);

    logic [DW-1:0] core [0:(1<<AW)-1];
    logic [CW-1:0] count;
    logic [AW-1:0] sp_inc, sp_dec, wa;
    logic          push_ok, pop_ok, repl, store, we;
    logic [2:0]    err_set;
    logic [DW-1:0] dat_comb, top_comb;

    assign full   = count == depth_c;
    assign empty  = count == '0;
    assign sp_inc = sp + one_a;
    assign sp_dec = sp - one_a;

    // Decode the cycle: stack ops take the write port ahead of stores; a push+pop on an empty stack degrades to a push.
    always_comb begin
        push_ok = push && (pop ? empty : !full);
        repl    = push && pop && !empty;
        pop_ok  = pop && !push && !empty;
        store   = wr_en && !push && !pop;
        err_set = {wr_en && (push || pop), pop && empty, push && !pop && full};
        we      = push_ok || repl || store;
        wa      = push_ok ? sp : repl ? sp_inc : addr;
    end

    // Stack pointer, depth and sticky errors; a new error outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= base_a;
            count <= '0;
            err   <= '0;
        end else begin
            sp    <= push_ok ? sp_dec : pop_ok ? sp_inc : sp;
            count <= push_ok ? count + one_c : pop_ok ? count - one_c : count;
            err   <= (err_clr ? 3'b000 : err) | err_set;
        end
    end

    // Single shared write port; contents survive reset but reset suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && we) core[wa] <= dat_in;
    end

    assign dat_comb = core[addr];
    assign top_comb = empty ? '0 : core[sp_inc];

`ifdef DAT_MEM_RD_REG_EN
    // Registered reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_out <= '0;
            stk_top <= '0;
        end else begin
            dat_out <= dat_comb;
            stk_top <= top_comb;
        end
    end
`else
    assign dat_out = dat_comb;
    assign stk_top = top_comb;
`endif
endmodule

// File: tb/tb_dat_mem_stk.sv
// tb_dat_mem_stk: scoreboard bench for dat_mem_stk; a behavioural model queues expected outputs per cycle, a negedge checker pops and compares.
module tb_dat_mem_stk;
    logic       clk = 0;
    logic       reset = 0;
    logic [7:0] addr = 0;
    logic [7:0] dat_in = 0;
    logic       wr_en = 0, push = 0, pop = 0, err_clr = 0;
    logic [7:0] dat_out, stk_top, sp;
    logic       full, empty;
    logic [2:0] err;

    dat_mem_stk dut (
        .clk(clk), .reset(reset), .addr(addr), .dat_in(dat_in), .wr_en(wr_en),
        .push(push), .pop(pop), .err_clr(err_clr), .dat_out(dat_out),
        .stk_top(stk_top), .sp(sp), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sp;
        logic       full;
        logic       empty;
        logic [2:0] err;
        logic [7:0] top;
        logic [7:0] dat;
        bit         dat_known;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    logic [7:0] m_mem [256];
    bit         m_known [256];
    int         m_sp = 255;
    int         m_cnt = 0;
    logic [2:0] m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [7:0] m_top();
        return m_cnt == 0 ? 8'h00 : m_mem[(m_sp + 1) & 255];
    endfunction

    task automatic step(input bit rs, input logic [7:0] a, input logic [7:0] d,
                        input bit w, input bit pu, input bit po, input bit ec);
        exp_t       e;
        logic [7:0] pre_dat, pre_top;
        bit         pre_known;
        logic [2:0] ne;
        reset = rs; addr = a; dat_in = d; wr_en = w; push = pu; pop = po; err_clr = ec;
        pre_dat = m_mem[a];
        pre_known = m_known[a];
        pre_top = m_top();
        @(posedge clk);
        ne = 0;
        if (rs) begin
            m_sp = 255; m_cnt = 0; m_err = 0;
        end else begin
            if (pu && po) begin
                if (m_cnt == 0) begin
                    m_mem[m_sp] = d; m_known[m_sp] = 1; m_sp--; m_cnt++; ne[1] = 1;
                end else begin
                    m_mem[m_sp + 1] = d; m_known[m_sp + 1] = 1;
                end
            end else if (pu) begin
                if (m_cnt == 64) ne[0] = 1;
                else begin
                    m_mem[m_sp] = d; m_known[m_sp] = 1; m_sp--; m_cnt++;
                end
            end else if (po) begin
                if (m_cnt == 0) ne[1] = 1;
                else begin
                    m_sp++; m_cnt--;
                end
            end
            if (w) begin
                if (pu || po) ne[2] = 1;
                else begin
                    m_mem[a] = d; m_known[a] = 1;
                end
            end
            m_err = (ec ? 3'b000 : m_err) | ne;
        end
        e.sp = 8'(m_sp);
        e.full = m_cnt == 64;
        e.empty = m_cnt == 0;
        e.err = m_err;
`ifdef DAT_MEM_RD_REG_EN
        e.top = rs ? 8'h00 : pre_top;
        e.dat = rs ? 8'h00 : pre_dat;
        e.dat_known = rs ? 1 : pre_known;
`else
        e.top = m_top();
        e.dat = m_mem[a];
        e.dat_known = m_known[a];
`endif
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sp", 32'(sp), 32'(e.sp));
            check("full", 32'(full), 32'(e.full));
            check("empty", 32'(empty), 32'(e.empty));
            check("err", 32'(err), 32'(e.err));
            check("stk_top", 32'(stk_top), 32'(e.top));
            if (e.dat_known) check("dat_out", 32'(dat_out), 32'(e.dat));
        end
    end

    task automatic op(input logic [7:0] a, input logic [7:0] d, input bit w,
                      input bit pu, input bit po, input bit ec);
        step(0, a, d, w, pu, po, ec);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 0;
            m_known[i] = 0;
        end
        @(negedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0);
        check("rst_sp", 32'(sp), 32'd255);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_top", 32'(stk_top), 32'd0);
        op(255, 8'hA1, 0, 1, 0, 0);
        op(255, 8'hB2, 0, 1, 0, 0);
        op(255, 0, 0, 0, 1, 0);
        op(255, 0, 0, 0, 1, 0);
        op(255, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) op(191, 8'(i + 8'h40), 0, 1, 0, 0);
        op(191, 8'hEE, 0, 1, 0, 0);
        op(191, 0, 0, 0, 0, 0);
        op(191, 0, 0, 0, 0, 1);
        op(191, 8'h99, 0, 1, 1, 0);
        for (int i = 0; i < 64; i++) op(255, 0, 0, 0, 1, 0);
        op(255, 0, 0, 0, 1, 0);
        op(255, 8'h5C, 0, 1, 1, 1);
        op(255, 8'h77, 0, 1, 1, 0);
        op(255, 0, 0, 0, 1, 1);
        op(8'h10, 8'h00, 1, 0, 0, 0);
        op(8'h10, 8'hFF, 1, 1, 0, 0);
        op(8'h10, 8'hFF, 1, 0, 0, 0);
        op(8'h10, 8'hFF, 0, 0, 0, 0);
        op(8'hFF, 8'hC3, 1, 0, 0, 1);
        op(8'hFF, 8'hC4, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) op(8'h10, 8'(i), 0, 1, 0, 0);
        step(1, 8'h10, 8'h55, 1, 1, 0, 0);
        op(8'h10, 0, 0, 0, 0, 0);
        op(255, 8'hA1, 0, 1, 0, 0);
        op(254, 8'hB2, 0, 1, 0, 0);
        op(254, 8'hD0, 1, 0, 0, 0);
        op(254, 0, 0, 0, 1, 0);
        op(254, 0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'(248 + $urandom_range(0, 7));
            op(a, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
